// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// Holds the controller state encoding, the default word-address width and
// a small helper that flags byte addresses that are not word aligned.
package dmem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int ST_W       = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  function automatic logic isMisaligned(input logic [1:0] byteOffset);
    return byteOffset != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_write_buffer.sv
// One-entry posted write buffer for the data-memory access unit.
// A store is parked here so the pipeline keeps moving while the write
// drains to memory in the background. The whole module exists only when
// DMEM_POSTED_WRITE_EN is defined; otherwise no buffer logic is built.
`ifdef DMEM_POSTED_WRITE_EN
module dmem_write_buffer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_pushAddr,
  input  logic [31:0]       i_pushData,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  // Fill the single entry on push, free it once its write has been acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_addr  <= i_pushAddr;
      r_data  <= i_pushData;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

endmodule
`endif

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory controller sitting between exmem and memwb.
// Issues one outstanding request at a time on a valid/ready memory port,
// returns load data to memwb and stalls the pipeline (data_ready_mem low)
// while an access is in flight. Misaligned accesses set a sticky flag and
// still access the containing word.
// Optional feature: define DMEM_POSTED_WRITE_EN to add a one-entry posted
// write buffer so stores retire without stalling.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_mem,
  input  logic              memwrite_mem,
  input  logic [31:0]       alu_result_mem,
  input  logic [31:0]       write_data_memory_mem,
  output logic [31:0]       data_from_memory_mem,
  output logic              data_ready_mem,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_rdata,
  output logic              misalign_err
);

  dmem_state_t r_state;
  dmem_state_t w_nextState;
  dmem_state_t w_rspState;

  logic              w_exOp;
  logic              w_misaligned;
  logic              w_launch;
  logic              w_launchWe;
  logic [ADDR_W-1:0] w_launchAddr;
  logic [31:0]       w_launchData;
  logic              w_flagMisalign;
  logic              w_accepted;
  logic              w_rspInWait;
  logic              w_unusedAddrHigh;

  logic              r_reqValid;
  logic              r_reqWe;
  logic [ADDR_W-1:0] r_reqAddr;
  logic [31:0]       r_reqWdata;
  logic [31:0]       r_loadData;
  logic              r_misalign;

  assign w_exOp           = memread_mem | memwrite_mem;
  assign w_misaligned     = isMisaligned(alu_result_mem[1:0]);
  assign w_unusedAddrHigh = ^alu_result_mem[31:ADDR_W+2];
  assign w_accepted       = (r_state == REQ) & r_reqValid & mem_req_ready;
  assign w_rspInWait      = (r_state == WAIT) & mem_rsp_valid;

`ifdef DMEM_POSTED_WRITE_EN
  logic              w_bufValid;
  logic [ADDR_W-1:0] w_bufAddr;
  logic [31:0]       w_bufData;
  logic              w_push;
  logic              w_pop;
  logic              w_startDrain;
  logic              w_startLoad;
  logic              r_drain;

  // A parked write always goes first; loads and further stores wait behind it
  assign w_startDrain   = (r_state == IDLE) & w_bufValid;
  assign w_startLoad    = (r_state == IDLE) & ~w_bufValid & memread_mem;
  assign w_push         = (r_state == IDLE) & ~w_bufValid & memwrite_mem & ~memread_mem;
  assign w_pop          = w_rspInWait & r_drain;
  assign w_launch       = w_startDrain | w_startLoad;
  assign w_launchWe     = w_startDrain;
  assign w_launchAddr   = w_startDrain ? w_bufAddr : alu_result_mem[ADDR_W+1:2];
  assign w_launchData   = w_startDrain ? w_bufData : write_data_memory_mem;
  assign w_flagMisalign = (w_startLoad | w_push) & w_misaligned;
  assign w_rspState     = r_drain ? IDLE : DONE;

  dmem_write_buffer #(
    .ADDR_W(ADDR_W)
  ) u_writeBuffer (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pushAddr(alu_result_mem[ADDR_W+1:2]),
    .i_pushData(write_data_memory_mem),
    .i_pop     (w_pop),
    .o_valid   (w_bufValid),
    .o_addr    (w_bufAddr),
    .o_data    (w_bufData)
  );

  // Remember whether the transaction in flight is a background drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain <= 1'b0;
    end else if (w_launch) begin
      r_drain <= w_startDrain;
    end
  end
`else
  // Loads and stores share the blocking path; a load wins if both are set
  assign w_launch       = (r_state == IDLE) & w_exOp;
  assign w_launchWe     = memwrite_mem & ~memread_mem;
  assign w_launchAddr   = alu_result_mem[ADDR_W+1:2];
  assign w_launchData   = write_data_memory_mem;
  assign w_flagMisalign = w_launch & w_misaligned;
  assign w_rspState     = DONE;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: launch, wait for acceptance, wait for response, release
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_nextState = REQ;
      REQ:     if (w_accepted) w_nextState = WAIT;
      WAIT:    if (mem_rsp_valid) w_nextState = w_rspState;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Pipeline advance: free when idle with nothing to do, or when an access completes
  always_comb begin
    data_ready_mem = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
    data_ready_mem = (r_state == DONE) | (~w_exOp & ((r_state == IDLE) | r_drain)) | w_push;
`else
    data_ready_mem = ((r_state == IDLE) & ~w_exOp) | (r_state == DONE);
`endif
  end

  // Request registers held stable until accepted; load data and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reqValid <= 1'b0;
      r_reqWe    <= 1'b0;
      r_reqAddr  <= '0;
      r_reqWdata <= '0;
      r_loadData <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_launch) begin
        r_reqValid <= 1'b1;
        r_reqWe    <= w_launchWe;
        r_reqAddr  <= w_launchAddr;
        r_reqWdata <= w_launchData;
      end else if (w_accepted) begin
        r_reqValid <= 1'b0;
      end
      if (w_rspInWait & ~r_reqWe) begin
        r_loadData <= mem_rsp_rdata;
      end
      if (w_flagMisalign) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign mem_req_valid        = r_reqValid;
  assign mem_req_we           = r_reqWe;
  assign mem_req_addr         = r_reqAddr;
  assign mem_req_wdata        = r_reqWdata;
  assign data_from_memory_mem = r_loadData;
  assign misalign_err         = r_misalign;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed testbench for dmem_access_unit with a scoreboarded memory model.
// Expected requests and load data are queued when an op is driven and
// checked when the memory accepts a request / the pipeline is released.
// Stall expectations adapt when DMEM_POSTED_WRITE_EN is defined.
module tb_dmem_access_unit;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } reqExp_t;

`ifdef DMEM_POSTED_WRITE_EN
  localparam int STORE_LOW            = 0;
  localparam int LOAD_AFTER_STORE_LOW = 6;
`else
  localparam int STORE_LOW            = 3;
  localparam int LOAD_AFTER_STORE_LOW = 3;
`endif

  logic        clk;
  logic        rst;
  logic        memread_mem;
  logic        memwrite_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_memory_mem;
  logic [31:0] data_from_memory_mem;
  logic        data_ready_mem;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [15:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        misalign_err;

  int          testsRun;
  int          testsFailed;
  int          rspDelay;
  int          stallReq;
  bit          spuriousReq;
  reqExp_t     reqQ[$];
  logic [31:0] dataQ[$];
  logic [31:0] memArr [0:255];

  dmem_access_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .memread_mem          (memread_mem),
    .memwrite_mem         (memwrite_mem),
    .alu_result_mem       (alu_result_mem),
    .write_data_memory_mem(write_data_memory_mem),
    .data_from_memory_mem (data_from_memory_mem),
    .data_ready_mem       (data_ready_mem),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_we           (mem_req_we),
    .mem_req_addr         (mem_req_addr),
    .mem_req_wdata        (mem_req_wdata),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_rdata        (mem_rsp_rdata),
    .misalign_err         (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one exmem op, queue its expectations, and wait (bounded) for release
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int expLow, input logic [31:0] expData);
    int          lowCnt;
    bit          sawReady;
    logic [31:0] dataBefore;
    logic [31:0] dataAtReady;
    logic [31:0] expOut;
    reqExp_t     r;
    lowCnt      = 0;
    sawReady    = 1'b0;
    dataBefore  = data_from_memory_mem;
    dataAtReady = 32'h0;
    memread_mem           = rd;
    memwrite_mem          = wr;
    alu_result_mem        = addr;
    write_data_memory_mem = wdata;
    if (rd | wr) begin
      r.we    = wr & ~rd;
      r.addr  = addr[17:2];
      r.wdata = wdata;
      reqQ.push_back(r);
    end
    if (rd) dataQ.push_back(expData);
    for (int i = 0; i < 64 && !sawReady; i++) begin
      @(negedge clk);
      if (data_ready_mem) begin
        sawReady    = 1'b1;
        dataAtReady = data_from_memory_mem;
      end else begin
        lowCnt++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_readySeen"}, 32'(sawReady), 32'd1);
    checkOutput({tag, "_stallCycles"}, 32'(lowCnt), 32'(expLow));
    if (rd && dataQ.size() > 0) expOut = dataQ.pop_front();
    else expOut = dataBefore;
    checkOutput({tag, "_dataOut"}, dataAtReady, expOut);
    memread_mem  = 1'b0;
    memwrite_mem = 1'b0;
  endtask

  // Memory model: checks requests against the scoreboard, answers after rspDelay cycles
  initial begin : memModel
    bit          accepted;
    logic        accWe;
    logic [15:0] accAddr;
    logic [31:0] accData;
    int          pendCnt;
    int          stallUsed;
    logic [31:0] pendData;
    for (int i = 0; i < 256; i++) memArr[i] = 32'h0;
    memArr[8'h10] = 32'hDEADBEEF;
    memArr[8'h11] = 32'hCAFEF00D;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    pendCnt   = 0;
    stallUsed = 0;
    pendData  = 32'h0;
    accWe     = 1'b0;
    accAddr   = 16'h0;
    accData   = 32'h0;
    forever begin
      @(negedge clk);
      accepted = 1'b0;
      if (!rst && mem_req_valid) begin
        checkOutput("reqExpected", 32'(reqQ.size() != 0), 32'd1);
        if (reqQ.size() != 0) begin
          checkOutput("reqWe", 32'(mem_req_we), 32'(reqQ[0].we));
          checkOutput("reqAddr", 32'(mem_req_addr), 32'(reqQ[0].addr));
          if (reqQ[0].we) checkOutput("reqWdata", mem_req_wdata, reqQ[0].wdata);
          if (mem_req_ready) begin
            accepted = 1'b1;
            accWe    = mem_req_we;
            accAddr  = mem_req_addr;
            accData  = mem_req_wdata;
            void'(reqQ.pop_front());
          end
        end
      end
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 32'hBADC0FFE;
      if (rst) begin
        pendCnt       = 0;
        stallUsed     = 0;
        mem_req_ready = 1'b1;
      end else begin
        if (accepted) begin
          checkOutput("singleOutstanding", 32'(pendCnt), 32'd0);
          if (accWe) begin
            memArr[accAddr[7:0]] = accData;
            pendData = 32'hBADC0FFE;
          end else begin
            pendData = memArr[accAddr[7:0]];
          end
          pendCnt   = rspDelay;
          stallUsed = 0;
        end
        if (pendCnt > 0) begin
          pendCnt--;
          if (pendCnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = pendData;
          end
        end else if (spuriousReq) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = 32'h0BADBAD0;
        end
        if (mem_req_valid && stallUsed < stallReq) begin
          mem_req_ready = 1'b0;
          stallUsed++;
        end else begin
          mem_req_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] keepData;
    reqExp_t     r;
    testsRun              = 0;
    testsFailed           = 0;
    rspDelay              = 1;
    stallReq              = 0;
    spuriousReq           = 1'b0;
    rst                   = 1'b1;
    memread_mem           = 1'b0;
    memwrite_mem          = 1'b0;
    alu_result_mem        = 32'h0;
    write_data_memory_mem = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(data_ready_mem), 32'd1);
    checkOutput("rst_reqValid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_reqWe", 32'(mem_req_we), 32'd0);
    checkOutput("rst_reqAddr", 32'(mem_req_addr), 32'd0);
    checkOutput("rst_reqWdata", mem_req_wdata, 32'd0);
    checkOutput("rst_dataOut", data_from_memory_mem, 32'd0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait load: three stall cycles, data on the fourth
    applyStimulus("t1_load40", 1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
    checkOutput("t1_misalign", 32'(misalign_err), 32'd0);

    // Response pulse while idle must not reach the data output
    #1;
    spuriousReq = 1'b1;
    @(posedge clk);
    #2;
    spuriousReq = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("spuriousRsp_dataOut", data_from_memory_mem, 32'hDEADBEEF);

    // Memory withholds ready for five cycles
    stallReq = 5;
    applyStimulus("t2_readyStall", 1'b1, 1'b0, 32'h44, 32'h0, 8, 32'hCAFEF00D);
    stallReq = 0;

    // Store followed immediately by a load of the same word
    applyStimulus("t3_store80", 1'b0, 1'b1, 32'h80, 32'h12345678, STORE_LOW, 32'h0);
    applyStimulus("t3_load80", 1'b1, 1'b0, 32'h80, 32'h0, LOAD_AFTER_STORE_LOW, 32'h12345678);

    // Read and write together behave as a load; memory stays unchanged
    applyStimulus("both_asLoad", 1'b1, 1'b1, 32'h80, 32'h55555555, 3, 32'h12345678);

    // Misaligned load: sticky flag, containing word accessed
    applyStimulus("t4_misaligned42", 1'b1, 1'b0, 32'h42, 32'h0, 3, 32'hDEADBEEF);
    checkOutput("t4_misalignSet", 32'(misalign_err), 32'd1);
    applyStimulus("t4_alignedAfter", 1'b1, 1'b0, 32'h44, 32'h0, 3, 32'hCAFEF00D);
    checkOutput("t4_misalignSticky", 32'(misalign_err), 32'd1);

`ifdef DMEM_POSTED_WRITE_EN
    // Posted store lets an unrelated op through while the write drains
    applyStimulus("t6_postStore", 1'b0, 1'b1, 32'h100, 32'hA5A50001, 0, 32'h0);
    applyStimulus("t6_aluOp", 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0);
    keepData = data_from_memory_mem;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_drainKeepsData", data_from_memory_mem, keepData);
    applyStimulus("t6_loadBack", 1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hA5A50001);
`endif

    // Reset while waiting for a slow response abandons the access
    rspDelay = 4;
    memread_mem    = 1'b1;
    alu_result_mem = 32'h48;
    r.we    = 1'b0;
    r.addr  = 16'h12;
    r.wdata = 32'h0;
    reqQ.push_back(r);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("t5_stalledInWait", 32'(data_ready_mem), 32'd0);
    #1;
    rst         = 1'b1;
    memread_mem = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_reqValid", 32'(mem_req_valid), 32'd0);
    checkOutput("t5_ready", 32'(data_ready_mem), 32'd1);
    checkOutput("t5_dataOut", data_from_memory_mem, 32'd0);
    checkOutput("t5_misalignCleared", 32'(misalign_err), 32'd0);
    #1;
    rst      = 1'b0;
    rspDelay = 1;
    @(posedge clk);
    #1;
    applyStimulus("t5_recoverLoad", 1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("end_reqQueueEmpty", 32'(reqQ.size()), 32'd0);
    checkOutput("end_dataQueueEmpty", 32'(dataQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
